memory_cycle: RTL

MEMORY_CYCLE -- requirements
Module: memory_cycle

---
 rtl/memory_cycle.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/memory_cycle.sv
// Memory stage of a 5-stage RV32 pipeline: 1 KiB word-indexed data memory with
// byte-lane stores, sign/zero-extending loads, an alignment fault check and the M/W pipeline register.
module memory_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic        StallM,
  input  logic        FlushM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic        FaultW
);

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  localparam logic [1:0] RES_LOAD = 2'b01;

  logic [31:0] mem [256];

  logic [7:0]  idx;
  logic [1:0]  off;
  logic        unused_addr;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        bad_align;
  logic        reserved;
  logic        unsigned_store;
  logic        fault;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rword;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic [31:0] load_val;
  logic [31:0] rdata_next;

  // Upper address bits are dropped so accesses wrap modulo 1 KiB.
  assign idx         = ALUResultM[9:2];
  assign off         = ALUResultM[1:0];
  assign unused_addr = ^ALUResultM[31:10];

  assign is_load        = (ResultSrcM == RES_LOAD);
  assign is_store       = MemWriteM;
  assign is_mem         = is_load | is_store;
  assign unsigned_store = is_store & ((funct3M == SZ_BU) | (funct3M == SZ_HU));
  assign fault          = is_mem & (bad_align | reserved | unsigned_store);

  // Writes are also blocked while rst is low so a store in flight at reset is dropped.
  assign we = is_store & ~fault & ~StallM & ~FlushM & rst;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    bad_align = 1'b0;
    reserved  = 1'b0;
    be        = 4'b0000;
    wdata     = WriteDataM;
    case (funct3M)
      SZ_B, SZ_BU: begin
        be    = 4'b0001 << off;
        wdata = {4{WriteDataM[7:0]}};
      end
      SZ_H, SZ_HU: begin
        bad_align = off[0];
        be        = off[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{WriteDataM[15:0]}};
      end
      SZ_W: begin
        bad_align = |off;
        be        = 4'b1111;
      end
      default: reserved = 1'b1;
    endcase
  end

  // NOTE: the data memory is intentionally never reset: contents must survive
  // rst, and a reset-free array maps onto a plain RAM macro.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_comb begin
    rword    = mem[idx];
    lbyte    = 8'(rword >> {off, 3'b000});
    lhalf    = off[1] ? rword[31:16] : rword[15:0];
    load_val = 32'd0;
    case (funct3M)
      SZ_B:    load_val = {{24{lbyte[7]}}, lbyte};
      SZ_BU:   load_val = {24'd0, lbyte};
      SZ_H:    load_val = {{16{lhalf[15]}}, lhalf};
      SZ_HU:   load_val = {16'd0, lhalf};
      SZ_W:    load_val = rword;
      default: load_val = 32'd0;
    endcase
    rdata_next = (is_load && !fault) ? load_val : 32'd0;
  end

  // Flush outranks stall; a stall simply leaves every register untouched.
  // NOTE: non-blocking assignments make every register sample pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RD_W       <= 5'd0;
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      PCPlus4W   <= 32'd0;
      FaultW     <= 1'b0;
    end else if (FlushM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RD_W       <= 5'd0;
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      PCPlus4W   <= 32'd0;
      FaultW     <= 1'b0;
    end else if (!StallM) begin
      RegWriteW  <= RegWriteM & ~fault;
      ResultSrcW <= ResultSrcM;
      RD_W       <= RD_M;
      ALUResultW <= ALUResultM;
      ReadDataW  <= rdata_next;
      PCPlus4W   <= PCPlus4M;
      FaultW     <= fault;
    end
  end

endmodule
